// File: rtl/i2c_bit_ctrl_if.sv
// Command/response bundle between the byte layer and the I2C bit sequencer.
interface i2c_bit_ctrl_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_i;
  logic       cmd_bit_i;
  logic       rsp_valid_o;
  logic       rsp_bit_o;
  logic       busy_o;

  modport master (
    output cmd_valid_i, cmd_i, cmd_bit_i,
    input  cmd_ready_o, rsp_valid_o, rsp_bit_o, busy_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, cmd_bit_i,
    output cmd_ready_o, rsp_valid_o, rsp_bit_o, busy_o
  );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// I2C bit sequencer: START/STOP/WRITE/READ as four quarter-period SCL/SDA phases.
// Optional macro I2C_CLK_STRETCH_EN enables target clock stretching via scl_i.
module i2c_bit_ctrl #(
  parameter int CLK_IN   = 100_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  i2c_bit_ctrl_if.slave  bus,
  output logic           scl_o,
  output logic           sda_o,
  input  logic           scl_i,
  input  logic           sda_i
);
  localparam int Q  = CLK_IN / (4 * SCL_FREQ);
  localparam int CW = (Q > 2) ? $clog2(Q) : 1;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  if (Q < 2) begin : g_bad_q
    $error("i2c_bit_ctrl: CLK_IN/(4*SCL_FREQ) must be >= 2");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [1:0]    r_phase;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cmd;
  logic          r_bit;
  logic          r_sample;
  logic          r_ready;
  logic          r_rsp_valid;
  logic          r_rsp_bit;
  logic          r_busy;
  logic          r_scl;
  logic          r_sda;
  logic [1:0]    r_sda_sync;
  logic          w_stall;
  logic          w_last;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_sda_sync <= 2'b11;
    else          r_sda_sync <= {r_sda_sync[0], sda_i};
  end

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] r_scl_sync;
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_scl_sync <= 2'b11;
    else          r_scl_sync <= {r_scl_sync[0], scl_i};
  end
  // A target holding SCL low while we release it stalls the high phases.
  assign w_stall = (r_state == S_RUN) && (r_phase == 2'd1 || r_phase == 2'd2) && !r_scl_sync[1];
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_stall      = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(Q - 1));

  // {scl, sda} for a given command and phase.
  function automatic logic [1:0] f_phase(input logic [1:0] c, input logic b, input logic [1:0] p);
    logic hi;
    hi = (p == 2'd1) || (p == 2'd2);
    case (c)
      CMD_START: f_phase = (p == 2'd0) ? 2'b11 : (p == 2'd3) ? 2'b00 : 2'b10;
      CMD_STOP:  f_phase = (p == 2'd0) ? 2'b00 : (p == 2'd1) ? 2'b10 : 2'b11;
      CMD_WRITE: f_phase = {hi, b};
      default:   f_phase = {hi, 1'b1};
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_bit       <= 1'b0;
      r_sample    <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_bit   <= 1'b0;
      r_busy      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid_i && r_ready) begin
            r_state        <= S_RUN;
            r_cmd          <= bus.cmd_i;
            r_bit          <= bus.cmd_bit_i;
            r_phase        <= 2'd0;
            r_cnt          <= '0;
            r_ready        <= 1'b0;
            {r_scl, r_sda} <= f_phase(bus.cmd_i, bus.cmd_bit_i, 2'd0);
          end
        end
        default: begin
          if (w_stall) begin
            r_cnt <= '0;
          end else if (w_last) begin
            r_cnt <= '0;
            if (r_phase == 2'd2) r_sample <= r_sda_sync[1];
            if (r_phase == 2'd3) begin
              r_state     <= S_IDLE;
              r_ready     <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_bit   <= r_cmd[1] ? r_sample : 1'b0;
              if (r_cmd == CMD_START)     r_busy <= 1'b1;
              else if (r_cmd == CMD_STOP) r_busy <= 1'b0;
            end else begin
              r_phase        <= r_phase + 2'd1;
              {r_scl, r_sda} <= f_phase(r_cmd, r_bit, r_phase + 2'd1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = r_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_bit_o   = r_rsp_bit;
  assign bus.busy_o      = r_busy;
  assign scl_o           = r_scl;
  assign sda_o           = r_sda;
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl at Q=2 (8 MHz clock, 1 MHz SCL).
module tb_i2c_bit_ctrl;
  logic clk = 1'b0;
  logic arstn;
  logic scl_o, sda_o, scl_i, sda_i;
  logic tb_pull, tb_hold;
  int   n_chk = 0;
  int   n_err = 0;

  i2c_bit_ctrl_if bus();

  // Open-drain pads: target may pull SDA low or hold SCL low.
  assign sda_i = sda_o & ~tb_pull;
  assign scl_i = ~tb_hold;

  i2c_bit_ctrl #(.CLK_IN(8_000_000), .SCL_FREQ(1_000_000)) dut (
    .clk_i(clk), .arstn_i(arstn), .bus(bus),
    .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns in cycle k+1 where k is the accept cycle.
  task automatic issue(input logic [1:0] c, input logic b);
    int t;
    t = 0;
    while (bus.cmd_ready_o !== 1'b1 && t < 50) begin
      step(1);
      t++;
    end
    chk("issue_ready", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = c;
    bus.cmd_bit_i   = b;
    step(1);
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    int rn;
    arstn = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i = 2'b00;
    bus.cmd_bit_i = 1'b0;
    tb_pull = 1'b0;
    tb_hold = 1'b0;
    step(2);
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_ready", bus.cmd_ready_o, 1);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_bit", bus.rsp_bit_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    arstn = 1'b1;
    step(2);

    // START
    issue(2'b00, 1'b0);
    chk("start_ph0", {scl_o, sda_o}, 2'b11);
    step(2);
    chk("start_ph1", {scl_o, sda_o}, 2'b10);
    step(4);
    chk("start_ph3_a", {scl_o, sda_o}, 2'b00);
    step(1);
    chk("start_ph3_b", {scl_o, sda_o}, 2'b00);
    chk("start_no_early_rsp", bus.rsp_valid_o, 0);
    step(1);
    chk("start_rsp", bus.rsp_valid_o, 1);
    chk("start_busy", bus.busy_o, 1);
    chk("start_rsp_bit", bus.rsp_bit_o, 0);

    // Back-to-back WRITE 1 then WRITE 0
    for (int w = 0; w < 2; w++) begin
      issue(2'b10, (w == 0));
      for (int n = 1; n <= 8; n++) begin
        chk("wr_ready_low", bus.cmd_ready_o, 0);
        chk("wr_scl", scl_o, (n >= 3 && n <= 6));
        chk("wr_sda", sda_o, (w == 0));
        step(1);
      end
      chk("wr_rsp", bus.rsp_valid_o, 1);
      chk("wr_rsp_bit", bus.rsp_bit_o, (w == 0));
      chk("wr_hold_scl", scl_o, 0);
    end

    // READ with target driving 0, then 1
    for (int r = 0; r < 2; r++) begin
      tb_pull = (r == 0);
      issue(2'b11, 1'b0);
      for (int n = 1; n <= 8; n++) begin
        chk("rd_sda_released", sda_o, 1);
        step(1);
      end
      chk("rd_rsp", bus.rsp_valid_o, 1);
      chk("rd_rsp_bit", bus.rsp_bit_o, (r == 1));
      step(1);
      chk("rd_rsp_one_cycle", bus.rsp_valid_o, 0);
      chk("rd_rsp_bit_held", bus.rsp_bit_o, (r == 1));
    end
    tb_pull = 1'b0;
    chk("busy_kept", bus.busy_o, 1);

    // STOP
    issue(2'b01, 1'b0);
    chk("stop_ph0", {scl_o, sda_o}, 2'b00);
    step(2);
    chk("stop_ph1", {scl_o, sda_o}, 2'b10);
    step(2);
    chk("stop_ph2", {scl_o, sda_o}, 2'b11);
    chk("stop_busy_mid", bus.busy_o, 1);
    step(4);
    chk("stop_rsp", bus.rsp_valid_o, 1);
    chk("stop_busy", bus.busy_o, 0);

    // WRITE with SCL held low by target for 10 cycles from k+3
    issue(2'b10, 1'b1);
    rn = -1;
    for (int n = 1; n <= 60 && rn < 0; n++) begin
      if (n == 3)  tb_hold = 1'b1;
      if (n == 13) tb_hold = 1'b0;
      if (bus.rsp_valid_o === 1'b1) rn = n;
      else step(1);
    end
    tb_hold = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    chk("stretch_rsp_delayed", (rn >= 19), 1);
`else
    chk("fixed_rsp_time", rn, 9);
`endif

    // START, then repeated START aborted by reset at k+4
    issue(2'b00, 1'b0);
    step(8);
    chk("start2_busy", bus.busy_o, 1);
    issue(2'b00, 1'b0);
    step(3);
    arstn = 1'b0;
    #1;
    chk("abort_scl", scl_o, 1);
    chk("abort_sda", sda_o, 1);
    chk("abort_ready", bus.cmd_ready_o, 1);
    chk("abort_busy", bus.busy_o, 0);
    step(2);
    arstn = 1'b1;
    for (int n = 0; n < 12; n++) begin
      chk("abort_no_rsp", bus.rsp_valid_o, 0);
      step(1);
    end
    chk("abort_idle_scl", scl_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
